// File: rtl/decode_pkg.sv
// Shared decode/encode vocabulary: decoded opcode enum, MIPS32 field codes
// and the FIFO entry format used by the instruction encoder.
package decode_pkg;

  typedef enum logic [6:0] {
    RESERVED,
    ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRA, SRL,
    JR, JALR, MFHI, MTHI, MFLO, MTLO, MOVN, MOVZ,
    ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI,
    LB, LH, LW, LBU, LHU, SB, SH, SW,
    LL, SC, LWL, LWR, SWL, SWR,
    BEQ, BNE, BGTZ, BLEZ, BGEZ, BLTZ, BGEZAL, BLTZAL,
    J, JAL, SYSCALL, BREAK,
    MFC0, MTC0, ERET, WAIT_EX, TLBR, TLBP, TLBWI,
    MUL, CLO, CLZ, MADD, MADDU, MSUB, MSUBU,
    CACHE
  } decoded_op_t;

  // Primary opcodes (bits 31:26)
  localparam logic [5:0] OP_RT    = 6'h00, OP_BGEZ  = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_PRIV  = 6'h10, OP_MUL   = 6'h1C;
  localparam logic [5:0] OP_LB    = 6'h20, OP_LH    = 6'h21, OP_LWL   = 6'h22, OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24, OP_LHU   = 6'h25, OP_LWR   = 6'h26, OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29, OP_SWL   = 6'h2A, OP_SW    = 6'h2B, OP_SWR   = 6'h2E;
  localparam logic [5:0] OP_CACHE = 6'h2F, OP_LL    = 6'h30, OP_SC    = 6'h38;

  // SPECIAL function codes (bits 5:0)
  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09, F_MOVZ = 6'h0A, F_MOVN = 6'h0B, F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_BREAK = 6'h0D, F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12;
  localparam logic [5:0] F_MTLO = 6'h13, F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  // SPECIAL2 function codes
  localparam logic [5:0] M_MADD = 6'h00, M_MADDU = 6'h01, M_MUL = 6'h02, M_MSUB = 6'h04;
  localparam logic [5:0] M_MSUBU = 6'h05, M_CLZ = 6'h20, M_CLO = 6'h21;

  // REGIMM rt-field codes
  localparam logic [4:0] B_BLTZ = 5'h00, B_BGEZ = 5'h01, B_BLTZAL = 5'h10, B_BGEZAL = 5'h11;

  // COP0: rs-field move codes and CO-format function codes
  localparam logic [4:0] C_MFC0 = 5'h00, C_MTC0 = 5'h04;
  localparam logic [5:0] C_TLBR = 6'h01, C_TLBWI = 6'h02, C_TLBP = 6'h08, C_ERET = 6'h18;
  localparam logic [5:0] C_WAIT = 6'h20;

  // Word layout selected per op; code carries the per-op field value
  typedef enum logic [3:0] {
    K_BAD, K_R, K_SYS, K_I, K_B0, K_REGIMM, K_J, K_CMOV, K_CFN, K_MUL
  } enc_kind_t;

  typedef struct packed {
    enc_kind_t  kind;
    logic [5:0] code;
  } enc_sel_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } encoded_entry_t;

endpackage

// File: rtl/instr_enc_comb.sv
// Pure combinational mapping from a decoded op plus fields to a MIPS32 word.
module instr_enc_comb
  import decode_pkg::*;
(
  input  decoded_op_t    op,
  input  logic [4:0]     rs,
  input  logic [4:0]     rt,
  input  logic [4:0]     rd,
  input  logic [4:0]     shamt,
  input  logic [25:0]    imm,
  output encoded_entry_t entry
);

  enc_sel_t sel;

  // Classify the op into a word layout and its distinguishing code
  always_comb begin
    sel = '{K_BAD, 6'h00};
    case (op)
      ADD:   sel = '{K_R, F_ADD};   ADDU:  sel = '{K_R, F_ADDU};  SUB:  sel = '{K_R, F_SUB};
      SUBU:  sel = '{K_R, F_SUBU};  AND:   sel = '{K_R, F_AND};   OR:   sel = '{K_R, F_OR};
      XOR:   sel = '{K_R, F_XOR};   NOR:   sel = '{K_R, F_NOR};   SLT:  sel = '{K_R, F_SLT};
      SLTU:  sel = '{K_R, F_SLTU};  SLL:   sel = '{K_R, F_SLL};   SRA:  sel = '{K_R, F_SRA};
      SRL:   sel = '{K_R, F_SRL};   JR:    sel = '{K_R, F_JR};    JALR: sel = '{K_R, F_JALR};
      MFHI:  sel = '{K_R, F_MFHI};  MTHI:  sel = '{K_R, F_MTHI};  MFLO: sel = '{K_R, F_MFLO};
      MTLO:  sel = '{K_R, F_MTLO};  MOVN:  sel = '{K_R, F_MOVN};  MOVZ: sel = '{K_R, F_MOVZ};
      ADDI:  sel = '{K_I, OP_ADDI}; ADDIU: sel = '{K_I, OP_ADDIU}; SLTI: sel = '{K_I, OP_SLTI};
      SLTIU: sel = '{K_I, OP_SLTIU}; ANDI: sel = '{K_I, OP_ANDI}; ORI:  sel = '{K_I, OP_ORI};
      XORI:  sel = '{K_I, OP_XORI}; LUI:   sel = '{K_I, OP_LUI};
      LB:    sel = '{K_I, OP_LB};   LH:    sel = '{K_I, OP_LH};   LW:   sel = '{K_I, OP_LW};
      LBU:   sel = '{K_I, OP_LBU};  LHU:   sel = '{K_I, OP_LHU};  SB:   sel = '{K_I, OP_SB};
      SH:    sel = '{K_I, OP_SH};   SW:    sel = '{K_I, OP_SW};   LL:   sel = '{K_I, OP_LL};
      SC:    sel = '{K_I, OP_SC};   LWL:   sel = '{K_I, OP_LWL};  LWR:  sel = '{K_I, OP_LWR};
      SWL:   sel = '{K_I, OP_SWL};  SWR:   sel = '{K_I, OP_SWR};  CACHE: sel = '{K_I, OP_CACHE};
      BEQ:   sel = '{K_I, OP_BEQ};  BNE:   sel = '{K_I, OP_BNE};
      BGTZ:  sel = '{K_B0, OP_BGTZ}; BLEZ: sel = '{K_B0, OP_BLEZ};
      BGEZ:  sel = '{K_REGIMM, 6'(B_BGEZ)};    BLTZ:   sel = '{K_REGIMM, 6'(B_BLTZ)};
      BGEZAL: sel = '{K_REGIMM, 6'(B_BGEZAL)}; BLTZAL: sel = '{K_REGIMM, 6'(B_BLTZAL)};
      J:     sel = '{K_J, OP_J};    JAL:   sel = '{K_J, OP_JAL};
      SYSCALL: sel = '{K_SYS, F_SYSCALL}; BREAK: sel = '{K_SYS, F_BREAK};
      MFC0:  sel = '{K_CMOV, 6'(C_MFC0)}; MTC0: sel = '{K_CMOV, 6'(C_MTC0)};
      ERET:  sel = '{K_CFN, C_ERET}; WAIT_EX: sel = '{K_CFN, C_WAIT}; TLBR: sel = '{K_CFN, C_TLBR};
      TLBP:  sel = '{K_CFN, C_TLBP}; TLBWI: sel = '{K_CFN, C_TLBWI};
      MUL:   sel = '{K_MUL, M_MUL}; CLO:   sel = '{K_MUL, M_CLO}; CLZ:  sel = '{K_MUL, M_CLZ};
      MADD:  sel = '{K_MUL, M_MADD}; MADDU: sel = '{K_MUL, M_MADDU};
      MSUB:  sel = '{K_MUL, M_MSUB}; MSUBU: sel = '{K_MUL, M_MSUBU};
      default: sel = '{K_BAD, 6'h00};
    endcase
  end

  // Assemble the machine word for the selected layout; unknown ops flag err
  always_comb begin
    entry = '0;
    case (sel.kind)
      K_R:      entry.instr = {OP_RT, rs, rt, rd, shamt, sel.code};
      K_SYS:    entry.instr = {OP_RT, imm[19:0], sel.code};
      K_I:      entry.instr = {sel.code, (op == LUI) ? 5'd0 : rs, rt, imm[15:0]};
      K_B0:     entry.instr = {sel.code, rs, 5'd0, imm[15:0]};
      K_REGIMM: entry.instr = {OP_BGEZ, rs, sel.code[4:0], imm[15:0]};
      K_J:      entry.instr = {sel.code, imm};
      K_CMOV:   entry.instr = {OP_PRIV, sel.code[4:0], rt, rd, 11'd0};
      K_CFN:    entry.instr = {OP_PRIV, 1'b1, 19'd0, sel.code};
      K_MUL:    entry.instr = {OP_MUL, rs, rt, rd, 5'd0, sel.code};
      default:  entry.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: encodes each accepted request and queues the word
// in a DEPTH-entry FIFO toward the consumer.
module instr_encoder
  import decode_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  decoded_op_t              in_op,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_shamt,
  input  logic [25:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  encoded_entry_t enc;
  encoded_entry_t mem [DEPTH];
  encoded_entry_t head;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           live;
  logic           push, pop;

  instr_enc_comb u_enc (
    .op    (in_op),
    .rs    (in_rs),
    .rt    (in_rt),
    .rd    (in_rd),
    .shamt (in_shamt),
    .imm   (in_imm),
    .entry (enc)
  );

  // live holds in_ready low until the first edge after reset release
  assign in_ready  = live && (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];
  // Output is masked while empty so stale storage never reaches the port
  assign out_instr = out_valid ? head.instr : '0;
  assign out_err   = out_valid ? head.err : 1'b0;

  // Storage write on accept; contents are don't-care until counted valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc;
  end

  // Pointers, occupancy and ready gating; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      live <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, FIFO flow control and reset.
module tb_instr_encoder;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  decoded_op_t in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [25:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [2:0]  count;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  instr_encoder #(.DEPTH(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_shamt  (in_shamt),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    assert (got === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic put(input decoded_op_t op, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_shamt = sh;
    in_imm   = imm;
  endtask

  // Push one request with out_ready high, then check the new head word
  task automatic xfer(input string tag, input decoded_op_t op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                      input logic [25:0] imm, input logic [31:0] exp, input logic exp_err);
    put(op, rs, rt, rd, sh, imm);
    tick;
    chk(tag, out_instr, exp);
    chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = RESERVED; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0;
    tick; tick;
    chk("rst_count",     32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_err",   32'(out_err), 32'd0);

    resetn = 1'b1;
    tick;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single ADDU, visible one cycle after accept
    put(ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0);
    tick;
    in_valid = 1'b0;
    chk("addu_valid", 32'(out_valid), 32'd1);
    chk("addu_instr", out_instr, 32'h00221821);
    chk("addu_err",   32'(out_err), 32'd0);
    chk("addu_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick;
    chk("addu_pop_count", 32'(count), 32'd0);

    // Streaming: push and pop in the same cycle, one word per cycle
    xfer("addiu",   ADDIU,   5'd0, 5'd4, 5'd0,  5'd0, 26'h0001234, 32'h24041234, 1'b0);
    xfer("j",       J,       5'd0, 5'd0, 5'd0,  5'd0, 26'h0100000, 32'h08100000, 1'b0);
    chk("stream_count", 32'(count), 32'd1);
    xfer("eret",    ERET,    5'd7, 5'd7, 5'd7,  5'd0, 26'd0,       32'h42000018, 1'b0);
    xfer("syscall", SYSCALL, 5'd0, 5'd0, 5'd0,  5'd0, 26'd0,       32'h0000000C, 1'b0);
    xfer("mfc0",    MFC0,    5'd0, 5'd8, 5'd12, 5'd0, 26'd0,       32'h40086000, 1'b0);
    xfer("lui",     LUI,     5'd5, 5'd3, 5'd0,  5'd0, 26'h000ABCD, 32'h3C03ABCD, 1'b0);
    xfer("bgezal",  BGEZAL,  5'd2, 5'd9, 5'd0,  5'd0, 26'h0000010, 32'h04510010, 1'b0);
    xfer("bgtz",    BGTZ,    5'd4, 5'd9, 5'd0,  5'd0, 26'h0000020, 32'h1C800020, 1'b0);
    xfer("mul",     MUL,     5'd1, 5'd2, 5'd3,  5'd0, 26'd0,       32'h70221802, 1'b0);
    xfer("srl",     SRL,     5'd0, 5'd2, 5'd3,  5'd4, 26'd0,       32'h00021902, 1'b0);
    xfer("reserved", RESERVED, 5'd3, 5'd3, 5'd3, 5'd3, 26'h000FFFF, 32'h00000000, 1'b1);
    xfer("op_above_cache", decoded_op_t'(7'd127), 5'd1, 5'd1, 5'd1, 5'd1, 26'h1, 32'h0, 1'b1);
    in_valid = 1'b0;
    tick;
    chk("stream_drained", 32'(count), 32'd0);

    // Fill with consumer stalled: 4 accepted, 5th held off
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      put(ADDIU, 5'd0, 5'd4, 5'd0, 5'd0, 26'(i));
      tick;
    end
    chk("full_count",    32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    put(ADDIU, 5'd0, 5'd4, 5'd0, 5'd0, 26'd5);
    tick;
    chk("full_hold_count", 32'(count), 32'd4);
    chk("full_hold_ready", 32'(in_ready), 32'd0);
    chk("full_hold_head",  out_instr, 32'h24040001);

    // One pop while full with a request pending: pop only, then push
    out_ready = 1'b1;
    tick;
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_head",  out_instr, 32'h24040002);
    out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    chk("refill_count", 32'(count), 32'd4);

    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("drain_%0d", i), out_instr, 32'h24040000 | 32'(i));
      tick;
    end
    chk("drain_count", 32'(count), 32'd0);

    // Asynchronous reset with 3 entries buffered
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      put(ADDIU, 5'd0, 5'd4, 5'd0, 5'd0, 26'(16 + i));
      tick;
    end
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd3);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd0);
    chk("async_rst_instr", out_instr, 32'h0);
    tick;
    resetn = 1'b1;
    tick;
    put(ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0);
    tick;
    in_valid = 1'b0;
    chk("post_rst_head",  out_instr, 32'h00221821);
    chk("post_rst_count", 32'(count), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO entry count (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request carries an instruction to encode.
REQ-005 SHALL have port in_ready  output  1  block accepts the request this cycle.
REQ-006 SHALL have port in_op  input  7  decoded_op_t opcode to encode.
REQ-007 SHALL have ports in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift fields.
REQ-008 SHALL have port in_imm  input  26  immediate; [15:0] for I-type, [25:0] for J-type, [19:0] for SYSCALL/BREAK code.
REQ-009 SHALL have port out_valid  output  1  FIFO head holds an encoded word.
REQ-010 SHALL have port out_ready  input  1  consumer takes the head word this cycle.
REQ-011 SHALL have port out_instr  output  32  encoded MIPS32 machine word at FIFO head.
REQ-012 SHALL have port out_err  output  1  head entry came from an unencodable op.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 SHALL accept a request when in_valid && in_ready; in_ready = (count < DEPTH), no pass-through when full.
REQ-015 SHALL register the encoded word into the FIFO on the accepting edge; it appears on out_instr one cycle later when FIFO was empty (latency 1).
REQ-016 SHALL pop the head when out_valid && out_ready; out_valid = (count != 0).
REQ-017 SHALL, on simultaneous push and pop, keep count unchanged and preserve order.
REQ-018 SHALL implement read/write pointers wrapping modulo DEPTH.
REQ-019 SHALL hold out_instr/out_err stable while out_valid && !out_ready.
REQ-020 SHALL encode R-type (ADD..SRL, JR, JALR, MFHI..MTLO, MOVN, MOVZ) as {OP_RT, rs, rt, rd, shamt, F_code}.
REQ-021 SHALL encode I-type arithmetic, loads, stores, LL, SC, LWL..SWR, CACHE, BEQ, BNE as {op6, rs, rt, imm[15:0]}; LUI forces rs=0.
REQ-022 SHALL encode BGTZ/BLEZ with rt=0, and BGEZ/BLTZ/BGEZAL/BLTZAL as {OP_BGEZ, rs, B_code, imm[15:0]}.
REQ-023 SHALL encode J/JAL as {op6, imm[25:0]}.
REQ-024 SHALL encode SYSCALL/BREAK as {OP_RT, imm[19:0], F_code}.
REQ-025 SHALL encode MFC0/MTC0 as {OP_PRIV, C_code, rt, rd, 11'b0}; ERET/WAIT_EX/TLBR/TLBP/TLBWI as {OP_PRIV, 1'b1, 19'b0, C_code}.
REQ-026 SHALL encode MUL, CLO, CLZ, MADD(U), MSUB(U) as {OP_MUL, rs, rt, rd, 5'b0, M_code}.
REQ-027 SHALL encode RESERVED or any value above CACHE as 32'h0000_0000 with err flag set; the entry is still enqueued.

Reset
REQ-028 SHALL, while resetn low, force count=0, pointers=0, out_valid=0, in_ready=0, out_instr=0, out_err=0.
REQ-029 SHALL discard all buffered entries when reset asserts mid-operation; no partial word survives.
REQ-030 SHALL raise in_ready on the first clock edge after resetn deasserts.

Structure
REQ-031 SHALL use decoded_op_t and the OP_/F_/M_/B_/C_ constants from decode_pkg; no local copies.
REQ-032 SHALL place a new encoded_entry_t {instr, err} struct in decode_pkg.
REQ-033 SHALL contain one sub-module, instr_enc_comb (pure combinational op-to-word mapping); FIFO stays in top.

Verification
REQ-034 SHALL test ADDU rs=1 rt=2 rd=3 -> out_instr 0x00221821, out_err 0, one cycle after accept.
REQ-035 SHALL test ADDIU rs=0 rt=4 imm=0x1234, J imm=0x0100000, ERET, SYSCALL imm=0, MFC0 rt=8 rd=12 -> 0x24041234, 0x08100000, 0x42000018, 0x0000000C, 0x40086000 in order.
REQ-036 SHALL test out_ready=0 with 5 requests -> 4 accepted, in_ready=0, count=4; then release -> words drain in issue order.
REQ-037 SHALL test full FIFO with in_valid && out_ready -> pop only that cycle, push the next, count returns to 4.
REQ-038 SHALL test op=RESERVED -> out_instr 0x00000000, out_err 1.
REQ-039 SHALL test resetn low with 3 entries buffered -> out_valid 0, count 0 immediately; post-reset first output is the next request.
